// File: rtl/tia_pkg.sv
// rtl/tia_pkg.sv - shared TIA timing constants and scan controller state encoding
//
// Purpose : default NTSC-style TIA beam timing plus the scan controller state
//           type, shared by the scan controller and the TIA register block.
// Ports   : none (package).
package tia_pkg;

  // Colour clocks per line, visible colour clocks, lines per frame.
  localparam int TIA_H_TOTAL     = 228;
  localparam int TIA_H_VISIBLE   = 160;
  localparam int TIA_V_TOTAL     = 262;
  // Lines forwarded to the LCD, and the drawn window [first, last).
  localparam int TIA_V_LCD       = 240;
  localparam int TIA_V_FIRST     = 24;
  localparam int TIA_V_LAST      = 226;
  // Idle cycles granted to the LCD writer after each pixel strobe.
  localparam int TIA_PACE_CYCLES = 8;

  typedef enum logic [1:0] {
    SCAN_IDLE = 2'd0,
    SCAN_SYNC = 2'd1,
    SCAN_RUN  = 2'd2,
    SCAN_PACE = 2'd3
  } scan_state_e;

  // Counter width able to hold the pace count itself; never narrower than 1.
  function automatic int pace_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/tia_pace_timer.sv
// rtl/tia_pace_timer.sv - loadable down-counter with done flag for pixel pacing
//
// Purpose : holds the scan controller in PACE for a programmed number of
//           cycles after each pixel strobe.
// Ports   : clk_i       - clock
//           rst_i       - synchronous active-high reset (count to 0)
//           load_i      - load load_val_i into the counter
//           clr_i       - abandon the current count (count to 0)
//           load_val_i  - value loaded on load_i
//           done_o      - high in the last cycle of the count (count <= 1)
module tia_pace_timer
  import tia_pkg::*;
#(
  parameter int WIDTH = pace_width(TIA_PACE_CYCLES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_o
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A load of N gives N cycles with the counter at N..1; the cycle showing 1
  // is the last one, so the owner leaves on that cycle's edge.
  assign done_o = (r_cnt <= WIDTH'(1));

endmodule

// File: rtl/tia_scan_ctrl.sv
// rtl/tia_scan_ctrl.sv - TIA beam position / LCD pixel pacing / WSYNC stall controller
//
// Purpose : walks the TIA beam (hpos, vpos), requests one LCD pixel write per
//           visible colour clock with a pacing gap, drives the WSYNC CPU stall
//           and restarts the frame on VSYNC.
// Ports   : clk_i        - clock
//           rst_i        - synchronous active-high reset
//           vsync_stb_i  - one-cycle pulse, VSYNC written with D1=1
//           wsync_stb_i  - one-cycle pulse, WSYNC written
//           lcd_busy_i   - LCD writer busy, freezes the beam while in RUN
//           pix_stb_o    - one-cycle pixel write request
//           pix_sub_o    - sub-pixel index of the current strobe
//           cursor_rst_o - one-cycle LCD cursor reset (in SYNC)
//           hpos_o       - current colour clock
//           vpos_o       - current line
//           draw_o       - render playfield/objects, else black
//           stall_cpu_o  - CPU stall (WSYNC until hblank)
//           frame_o      - one-cycle pulse on SYNC or vpos wrap
// Macro   : TIA_SCAN_HDOUBLE_EN - two paced strobes per visible colour clock
//           (pix_sub_o 0 then 1), giving 320 LCD pixels per line.
module tia_scan_ctrl
  import tia_pkg::*;
#(
  parameter int H_TOTAL     = TIA_H_TOTAL,
  parameter int H_VISIBLE   = TIA_H_VISIBLE,
  parameter int V_TOTAL     = TIA_V_TOTAL,
  parameter int V_LCD       = TIA_V_LCD,
  parameter int V_FIRST     = TIA_V_FIRST,
  parameter int V_LAST      = TIA_V_LAST,
  parameter int PACE_CYCLES = TIA_PACE_CYCLES
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       vsync_stb_i,
  input  logic       wsync_stb_i,
  input  logic       lcd_busy_i,
  output logic       pix_stb_o,
  output logic       pix_sub_o,
  output logic       cursor_rst_o,
  output logic [7:0] hpos_o,
  output logic [8:0] vpos_o,
  output logic       draw_o,
  output logic       stall_cpu_o,
  output logic       frame_o
);

  localparam int                PACE_W    = pace_width(PACE_CYCLES);
  localparam logic [PACE_W-1:0] PACE_LOAD = PACE_W'(PACE_CYCLES);

  // Wrap points are exact equality compares against the last position, so
  // the counters never run past their totals.
  localparam logic [7:0] H_LAST    = 8'(H_TOTAL - 1);
  localparam logic [7:0] H_VIS     = 8'(H_VISIBLE);
  localparam logic [8:0] V_LASTLN  = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_LCD_END = 9'(V_LCD);
  localparam logic [8:0] V_DRAW_LO = 9'(V_FIRST);
  localparam logic [8:0] V_DRAW_HI = 9'(V_LAST);

  scan_state_e r_state;
  scan_state_e w_state_nxt;

  logic [7:0] r_hpos;
  logic [7:0] w_hpos_nxt;
  logic [8:0] r_vpos;
  logic [8:0] w_vpos_nxt;
  logic       r_stall;
  logic       w_stall_nxt;
  logic       r_wrap;
  logic       w_wrap_nxt;

  logic       w_visible;
  logic       w_active;
  logic       w_strobe;
  logic       w_advance;
  logic       w_pace_load;
  logic       w_pace_clr;
  logic       w_pace_done;

`ifdef TIA_SCAN_HDOUBLE_EN
  logic       r_sub;
  logic       w_sub_nxt;
`endif

  tia_pace_timer #(
    .WIDTH (PACE_W)
  ) u_pace (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (w_pace_load),
    .clr_i      (w_pace_clr),
    .load_val_i (PACE_LOAD),
    .done_o     (w_pace_done)
  );

  assign w_visible = (r_hpos < H_VIS) && (r_vpos < V_LCD_END);
  assign w_active  = (r_state == SCAN_RUN) || (r_state == SCAN_PACE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= SCAN_IDLE;
      r_hpos  <= '0;
      r_vpos  <= '0;
      r_stall <= 1'b0;
      r_wrap  <= 1'b0;
`ifdef TIA_SCAN_HDOUBLE_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_hpos  <= w_hpos_nxt;
      r_vpos  <= w_vpos_nxt;
      r_stall <= w_stall_nxt;
      r_wrap  <= w_wrap_nxt;
`ifdef TIA_SCAN_HDOUBLE_EN
      r_sub   <= w_sub_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hpos_nxt  = r_hpos;
    w_vpos_nxt  = r_vpos;
    w_stall_nxt = r_stall;
    w_wrap_nxt  = 1'b0;
    w_strobe    = 1'b0;
    w_advance   = 1'b0;
    w_pace_load = 1'b0;
    w_pace_clr  = 1'b0;
`ifdef TIA_SCAN_HDOUBLE_EN
    w_sub_nxt   = r_sub;
`endif

    if (vsync_stb_i) begin
      // VSYNC pre-empts everything, including a tick due this cycle, so
      // SYNC already shows the beam at the origin.
      w_state_nxt = SCAN_SYNC;
      w_hpos_nxt  = '0;
      w_vpos_nxt  = '0;
      w_stall_nxt = 1'b0;
      w_pace_clr  = 1'b1;
`ifdef TIA_SCAN_HDOUBLE_EN
      w_sub_nxt   = 1'b0;
`endif
    end else begin
      unique case (r_state)
        SCAN_IDLE: begin
          w_state_nxt = SCAN_IDLE;
        end
        SCAN_SYNC: begin
          w_state_nxt = SCAN_RUN;
        end
        SCAN_RUN: begin
          if (!lcd_busy_i) begin
            if (w_visible) begin
              w_strobe    = 1'b1;
              w_pace_load = 1'b1;
              w_state_nxt = SCAN_PACE;
`ifdef TIA_SCAN_HDOUBLE_EN
              // The beam only moves on the second half of the pixel pair.
              if (!r_sub) begin
                w_sub_nxt = 1'b1;
              end else begin
                w_sub_nxt = 1'b0;
                w_advance = 1'b1;
              end
`else
              w_advance = 1'b1;
`endif
            end else begin
              w_advance = 1'b1;
            end
          end
        end
        SCAN_PACE: begin
          if (w_pace_done) begin
            w_state_nxt = SCAN_RUN;
          end
        end
        default: begin
          w_state_nxt = SCAN_IDLE;
        end
      endcase
    end

    if (w_advance) begin
      if (r_hpos == H_LAST) begin
        w_hpos_nxt = '0;
        if (r_vpos == V_LASTLN) begin
          w_vpos_nxt = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_vpos_nxt = r_vpos + 9'd1;
        end
      end else begin
        w_hpos_nxt = r_hpos + 8'd1;
      end
      // Stall releases on the tick that enters hblank.
      if (w_hpos_nxt == H_VIS) begin
        w_stall_nxt = 1'b0;
      end
    end

    // Set is evaluated last so a WSYNC landing on the releasing tick keeps
    // the CPU held until the following line's hblank.
    if (wsync_stb_i && (r_state != SCAN_IDLE)) begin
      w_stall_nxt = 1'b1;
    end
  end

  assign pix_stb_o    = w_strobe;
  assign cursor_rst_o = (r_state == SCAN_SYNC);
  assign frame_o      = (r_state == SCAN_SYNC) || r_wrap;
  assign hpos_o       = r_hpos;
  assign vpos_o       = r_vpos;
  assign stall_cpu_o  = r_stall;
  assign draw_o       = w_active && (r_vpos >= V_DRAW_LO) && (r_vpos < V_DRAW_HI)
                        && (r_hpos < H_VIS);

`ifdef TIA_SCAN_HDOUBLE_EN
  assign pix_sub_o = r_sub;
`else
  assign pix_sub_o = 1'b0;
`endif

endmodule

// File: tb/tb_tia_scan_ctrl.sv
// tb/tb_tia_scan_ctrl.sv - directed self-checking bench for tia_scan_ctrl
module tb_tia_scan_ctrl;

  localparam int PACE   = 8;
  localparam int BUDGET = 70000;
`ifdef TIA_SCAN_HDOUBLE_EN
  localparam int SUBS = 2;
`else
  localparam int SUBS = 1;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       vsync_stb_i;
  logic       wsync_stb_i;
  logic       lcd_busy_i;
  logic       pix_stb_o;
  logic       pix_sub_o;
  logic       cursor_rst_o;
  logic [7:0] hpos_o;
  logic [8:0] vpos_o;
  logic       draw_o;
  logic       stall_cpu_o;
  logic       frame_o;

  int n_cmp       = 0;
  int n_bad       = 0;
  int frames_seen = 0;

  always #5 clk_i = ~clk_i;

  tia_scan_ctrl #(
    .V_LCD (2)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .vsync_stb_i  (vsync_stb_i),
    .wsync_stb_i  (wsync_stb_i),
    .lcd_busy_i   (lcd_busy_i),
    .pix_stb_o    (pix_stb_o),
    .pix_sub_o    (pix_sub_o),
    .cursor_rst_o (cursor_rst_o),
    .hpos_o       (hpos_o),
    .vpos_o       (vpos_o),
    .draw_o       (draw_o),
    .stall_cpu_o  (stall_cpu_o),
    .frame_o      (frame_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
    if (frame_o) frames_seen++;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_hv(input string tag, input int h, input int v);
    int n;
    n = 0;
    while (!(int'(hpos_o) == h && int'(vpos_o) == v) && n < BUDGET) begin
      step();
      n++;
    end
    check({tag, "_reached"}, int'(int'(hpos_o) == h && int'(vpos_o) == v), 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, last, nstb, bad_gap, bad_h, bad_sub, dwell, bad;

    rst_i = 1'b1; vsync_stb_i = 1'b0; wsync_stb_i = 1'b0; lcd_busy_i = 1'b0;
    step(); step();
    check("rst_flags", int'({pix_stb_o, pix_sub_o, cursor_rst_o, frame_o, draw_o, stall_cpu_o}), 0);
    check("rst_hpos", int'(hpos_o), 0);
    check("rst_vpos", int'(vpos_o), 0);
    rst_i = 1'b0;

    wsync_stb_i = 1'b1; step(); wsync_stb_i = 1'b0; step();
    check("idle_wsync_ignored", int'(stall_cpu_o), 0);
    step(); step();
    check("idle_no_scan", int'({hpos_o, pix_stb_o}), 0);

    vsync_stb_i = 1'b1; step(); vsync_stb_i = 1'b0;
    check("sync_cursor_rst", int'(cursor_rst_o), 1);
    check("sync_frame", int'(frame_o), 1);
    check("sync_pos", int'({hpos_o, vpos_o}), 0);
    check("sync_no_strobe", int'(pix_stb_o), 0);
    frames_seen = 0;
    step();
    check("run_cursor_rst_drop", int'({cursor_rst_o, frame_o}), 0);
    check("first_strobe", int'(pix_stb_o), 1);
    check("first_strobe_pos", int'({hpos_o, vpos_o}), 0);
    check("first_strobe_draw", int'(draw_o), 0);
    check("first_strobe_sub", int'(pix_sub_o), 0);

    // Line 0: every visible strobe, its spacing, position and sub index.
    cyc = 0; last = 0; nstb = 0; bad_gap = 0; bad_h = 0; bad_sub = 0;
    while (int'(hpos_o) != 160 && cyc < 8000) begin
      if (pix_stb_o) begin
        if (nstb > 0 && (cyc - last) != PACE + 1) bad_gap++;
        if (int'(hpos_o) != nstb / SUBS || vpos_o != 9'd0 || draw_o) bad_h++;
        if (int'(pix_sub_o) != nstb % SUBS) bad_sub++;
        last = cyc;
        nstb++;
      end
      step();
      cyc++;
    end
    check("line0_strobe_count", nstb, 160 * SUBS);
    check("line0_strobe_gap", bad_gap, 0);
    check("line0_strobe_pos", bad_h, 0);
    check("line0_strobe_sub", bad_sub, 0);
    check("line0_reached_hblank", int'(hpos_o), 160);

    dwell = 0;
    while (int'(hpos_o) == 160 && dwell < 50) begin
      step();
      dwell++;
    end
    check("hblank_entry_dwell", dwell, PACE + 1);
    bad = 0;
    for (int h = 161; h < 228; h++) begin
      if (int'(hpos_o) != h || vpos_o != 9'd0 || pix_stb_o) bad++;
      step();
    end
    check("hblank_one_tick_per_cycle", bad, 0);
    check("hwrap_hpos", int'(hpos_o), 0);
    check("hwrap_vpos", int'(vpos_o), 1);
    check("line1_first_strobe", int'(pix_stb_o), 1);

    // Line 1: WSYNC mid-line, LCD busy freeze, stall release at hblank.
    wait_hv("wsync50", 50, 1);
    check("pre_wsync_stall", int'(stall_cpu_o), 0);
    wsync_stb_i = 1'b1; step(); wsync_stb_i = 1'b0;
    check("wsync_stall_set", int'(stall_cpu_o), 1);
    wait_hv("busy100", 100, 1);
    lcd_busy_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (hpos_o != 8'd100 || pix_stb_o) bad++;
    end
    check("busy_frozen", bad, 0);
    lcd_busy_i = 1'b0;
    #1;
    check("busy_resume_strobe", int'(pix_stb_o), 1);
    check("busy_resume_hpos", int'(hpos_o), 100);
    check("busy_resume_sub", int'(pix_sub_o), 0);
    wait_hv("stall159", 159, 1);
    check("stall_held_159", int'(stall_cpu_o), 1);
    wait_hv("stall160", 160, 1);
    check("stall_clear_160", int'(stall_cpu_o), 0);

    // Line 2 (not sent to LCD): WSYNC on the very tick that enters hblank.
    wait_hv("coinc159", 159, 2);
    check("coinc_pre_stall", int'(stall_cpu_o), 0);
    wsync_stb_i = 1'b1; step(); wsync_stb_i = 1'b0;
    check("coinc_hpos", int'(hpos_o), 160);
    check("coinc_set_wins", int'(stall_cpu_o), 1);
    wait_hv("coinc_next159", 159, 3);
    check("coinc_held_next_line", int'(stall_cpu_o), 1);
    wait_hv("coinc_next160", 160, 3);
    check("coinc_clear_next_line", int'(stall_cpu_o), 0);

    // Draw window.
    wait_hv("draw23", 100, 23);
    check("draw_v23", int'(draw_o), 0);
    wait_hv("draw24", 0, 24);
    bad = 0;
    for (int h = 0; h < 228; h++) begin
      if (int'(hpos_o) != h || int'(draw_o) != int'(h < 160) || pix_stb_o) bad++;
      step();
    end
    check("draw_v24_line", bad, 0);
    check("draw_v24_end", int'({hpos_o, vpos_o}), 25);
    wait_hv("draw225", 159, 225);
    check("draw_v225", int'(draw_o), 1);
    wait_hv("draw226", 0, 226);
    check("draw_v226", int'(draw_o), 0);

    // Free-running frame wrap after 262 lines.
    wait_hv("vwrap", 227, 261);
    check("pre_wrap_frame", int'(frame_o), 0);
    step();
    check("wrap_frame", int'(frame_o), 1);
    check("wrap_pos", int'({hpos_o, vpos_o}), 0);
    check("wrap_frames_seen", frames_seen, 1);
    check("wrap_cursor_quiet", int'(cursor_rst_o), 0);
    step();
    check("wrap_frame_drop", int'(frame_o), 0);

    // VSYNC while pacing at hpos 80 with the CPU stalled.
    wait_hv("abort70", 70, 1);
    wsync_stb_i = 1'b1; step(); wsync_stb_i = 1'b0;
    wait_hv("abort80", 80, 1);
    check("abort_pre_stall", int'(stall_cpu_o), 1);
    check("abort_in_pace", int'(pix_stb_o), 0);
    vsync_stb_i = 1'b1; step(); vsync_stb_i = 1'b0;
    check("abort_cursor_rst", int'(cursor_rst_o), 1);
    check("abort_frame", int'(frame_o), 1);
    check("abort_pos", int'({hpos_o, vpos_o}), 0);
    check("abort_stall", int'(stall_cpu_o), 0);
    step();
    check("abort_restart_strobe", int'(pix_stb_o), 1);
    check("abort_restart_hpos", int'(hpos_o), 0);

    // Reset while pacing and stalled.
    wsync_stb_i = 1'b1; step(); wsync_stb_i = 1'b0;
    check("midpace_stall", int'(stall_cpu_o), 1);
    rst_i = 1'b1; step();
    check("midpace_rst_flags", int'({pix_stb_o, pix_sub_o, cursor_rst_o, frame_o, draw_o, stall_cpu_o}), 0);
    check("midpace_rst_pos", int'({hpos_o, vpos_o}), 0);
    rst_i = 1'b0;
    step(); step(); step();
    check("post_rst_idle", int'({hpos_o, pix_stb_o}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
